pipeline_sequencer: RTL and testbench

//   Central control for the 5-stage MIPS pipeline. Drives the PC enable and PC

---
 rtl/pipe_ctrl_pkg.sv | 54 +++++
 rtl/go_edge_sync.sv | 43 ++++
 rtl/pipeline_sequencer.sv | 152 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared encodings for the 5-stage pipeline control path: FSM
//            state codes, PC source select codes and the control bundle.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer state encoding
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] HALTED = 2'd1;
    localparam logic [1:0] RESUME = 2'd2;

    // PC source select codes, shared with the PC mux
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    // Pipeline control bundle produced by the sequencer each cycle
    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       if_id_en;
        logic       if_id_flush;
        logic       id_ex_en;
        logic       id_ex_flush;
    } pipe_ctrl_t;

    // Free-running pipeline: everything advances, nothing is flushed
    localparam pipe_ctrl_t CTRL_RUN  = '{pc_en: 1'b1, pc_sel: PC_SEQ,
                                         if_id_en: 1'b1, if_id_flush: 1'b0,
                                         id_ex_en: 1'b1, id_ex_flush: 1'b0};

    // Frozen pipeline: nothing advances, nothing is flushed
    localparam pipe_ctrl_t CTRL_HOLD = '{pc_en: 1'b0, pc_sel: PC_SEQ,
                                         if_id_en: 1'b0, if_id_flush: 1'b0,
                                         id_ex_en: 1'b0, id_ex_flush: 1'b0};

    // Redirect source with priority jr > j > br; never returns X
    function automatic logic [1:0] redirect_sel(input logic jr,
                                                input logic j,
                                                input logic br);
        logic [1:0] sel;
        sel = PC_SEQ;
        if (jr)      sel = PC_JR;
        else if (j)  sel = PC_J;
        else if (br) sel = PC_BR;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/go_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : go_edge_sync
// Brief    : Multi-flop synchronizer for the asynchronous go button followed
//            by an edge flop; emits a one-cycle pulse on each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module go_edge_sync #(
    parameter int GO_SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic go_pulse
);

    logic [GO_SYNC-1:0] sync_q;
    logic [GO_SYNC-1:0] sync_d;
    logic               edge_q;
    logic               edge_d;

    // Shift the raw button into the synchronizer chain; remember last sample
    always_comb begin
        sync_d = {sync_q[GO_SYNC-2:0], go};
        edge_d = sync_q[GO_SYNC-1];
    end

    // Synchronizer and edge flops, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    // A level that has been high for a while produces no pulse
    assign go_pulse = sync_q[GO_SYNC-1] & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Brief    : Central control for the 5-stage MIPS pipeline. Sequences
//            load-use stalls, branch/jump redirects and syscall halt/resume,
//            and keeps the cycle/branch/bubble statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int GO_SYNC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             j_taken,
    input  logic             jr_taken,
    input  logic             halt_req,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             running,
    output logic [CNT_W-1:0] total_cycles,
    output logic [CNT_W-1:0] condi_num,
    output logic [CNT_W-1:0] uncondi_num,
    output logic [CNT_W-1:0] bubble_num
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    pipe_ctrl_t       ctrl;
    logic             go_pulse;
    logic             redirect;
    logic             inc_total;
    logic             inc_condi;
    logic             inc_uncondi;
    logic             inc_bubble;
    logic [CNT_W-1:0] total_cycles_q;
    logic [CNT_W-1:0] total_cycles_d;
    logic [CNT_W-1:0] condi_num_q;
    logic [CNT_W-1:0] condi_num_d;
    logic [CNT_W-1:0] uncondi_num_q;
    logic [CNT_W-1:0] uncondi_num_d;
    logic [CNT_W-1:0] bubble_num_q;
    logic [CNT_W-1:0] bubble_num_d;

    go_edge_sync #(
        .GO_SYNC (GO_SYNC)
    ) u_go_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .go_pulse (go_pulse)
    );

    assign redirect = br_taken | j_taken | jr_taken;

    // Next-state, pipeline control decode and counter qualifiers
    always_comb begin
        state_d     = state_q;
        ctrl        = CTRL_RUN;
        inc_total   = 1'b0;
        inc_condi   = 1'b0;
        inc_uncondi = 1'b0;
        inc_bubble  = 1'b0;
        case (state_q)
            RUN, RESUME: begin
                inc_total = 1'b1;
                // The syscall that caused the halt is still in WB during
                // RESUME, so halt_req is only honoured from RUN.
                if ((state_q == RUN) && halt_req) begin
                    ctrl    = CTRL_HOLD;
                    state_d = HALTED;
                end else begin
                    state_d = RUN;
                    if (redirect) begin
                        // Redirect wins over a stall: the stalled ID
                        // instruction is on the wrong path anyway.
                        ctrl.pc_sel      = redirect_sel(jr_taken, j_taken, br_taken);
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                        if (jr_taken || j_taken) begin
                            inc_uncondi = 1'b1;
                        end else begin
                            inc_condi = 1'b1;
                        end
                    end else if (load_use) begin
                        ctrl.pc_en       = 1'b0;
                        ctrl.if_id_en    = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                        inc_bubble       = 1'b1;
                    end
                end
            end
            HALTED: begin
                ctrl = CTRL_HOLD;
                if (go_pulse) begin
                    state_d = RESUME;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Statistics counters, wrapping modulo 2^CNT_W
    always_comb begin
        total_cycles_d = total_cycles_q + (inc_total   ? CNT_W'(1) : CNT_W'(0));
        condi_num_d    = condi_num_q    + (inc_condi   ? CNT_W'(1) : CNT_W'(0));
        uncondi_num_d  = uncondi_num_q  + (inc_uncondi ? CNT_W'(1) : CNT_W'(0));
        bubble_num_d   = bubble_num_q   + (inc_bubble  ? CNT_W'(1) : CNT_W'(0));
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            total_cycles_q <= '0;
            condi_num_q    <= '0;
            uncondi_num_q  <= '0;
            bubble_num_q   <= '0;
        end else begin
            state_q        <= state_d;
            total_cycles_q <= total_cycles_d;
            condi_num_q    <= condi_num_d;
            uncondi_num_q  <= uncondi_num_d;
            bubble_num_q   <= bubble_num_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign pc_sel       = ctrl.pc_sel;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign running      = (state_q != HALTED);
    assign total_cycles = total_cycles_q;
    assign condi_num    = condi_num_q;
    assign uncondi_num  = uncondi_num_q;
    assign bubble_num   = bubble_num_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Brief    : Scoreboard bench for pipeline_sequencer: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int CNT_W   = 4;
    localparam int GO_SYNC = 2;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst;
    logic             go;
    logic             load_use;
    logic             br_taken;
    logic             j_taken;
    logic             jr_taken;
    logic             halt_req;
    logic             pc_en;
    logic [1:0]       pc_sel;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             running;
    logic [CNT_W-1:0] total_cycles;
    logic [CNT_W-1:0] condi_num;
    logic [CNT_W-1:0] uncondi_num;
    logic [CNT_W-1:0] bubble_num;

    pipeline_sequencer #(
        .CNT_W   (CNT_W),
        .GO_SYNC (GO_SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .load_use     (load_use),
        .br_taken     (br_taken),
        .j_taken      (j_taken),
        .jr_taken     (jr_taken),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .running      (running),
        .total_cycles (total_cycles),
        .condi_num    (condi_num),
        .uncondi_num  (uncondi_num),
        .bubble_num   (bubble_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       pc_en;
        bit [1:0] pc_sel;
        bit       if_id_en;
        bit       if_id_flush;
        bit       id_ex_en;
        bit       id_ex_flush;
        bit       running;
        int       total;
        int       condi;
        int       uncondi;
        int       bubble;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // Pipeline mode: stopped after a syscall, or the one-cycle grace period
    // right after a resume in which the retiring syscall is ignored.
    bit m_stopped;
    bit m_grace;
    int m_total, m_condi, m_uncondi, m_bubble;
    // go level as seen at recent clock edges, newest first
    bit go_seen[$];

    function automatic void model_reset();
        m_stopped = 1'b0;
        m_grace   = 1'b0;
        m_total   = 0;
        m_condi   = 0;
        m_uncondi = 0;
        m_bubble  = 0;
        go_seen.delete();
        for (int i = 0; i <= GO_SYNC; i++) go_seen.push_back(1'b0);
    endfunction

    // Expected outputs for the current mode and the inputs now applied
    function automatic exp_t model_outputs();
        exp_t e;
        e.pc_en       = 1'b1;
        e.pc_sel      = 2'd0;
        e.if_id_en    = 1'b1;
        e.if_id_flush = 1'b0;
        e.id_ex_en    = 1'b1;
        e.id_ex_flush = 1'b0;
        e.running     = !m_stopped;
        e.total       = m_total % CNT_MOD;
        e.condi       = m_condi % CNT_MOD;
        e.uncondi     = m_uncondi % CNT_MOD;
        e.bubble      = m_bubble % CNT_MOD;
        if (m_stopped || (halt_req && !m_grace)) begin
            e.pc_en    = 1'b0;
            e.if_id_en = 1'b0;
            e.id_ex_en = 1'b0;
        end else if (jr_taken || j_taken || br_taken) begin
            e.pc_sel      = jr_taken ? 2'd3 : (j_taken ? 2'd2 : 2'd1);
            e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1;
        end else if (load_use) begin
            e.pc_en       = 1'b0;
            e.if_id_en    = 1'b0;
            e.id_ex_flush = 1'b1;
        end
        return e;
    endfunction

    // Effect of the coming clock edge with the inputs now applied
    function automatic void model_advance();
        // A fresh press is recognised once it has been seen at GO_SYNC edges
        bit press = go_seen[GO_SYNC-1] && !go_seen[GO_SYNC];
        if (m_stopped) begin
            if (press) begin
                m_stopped = 1'b0;
                m_grace   = 1'b1;
            end
        end else begin
            m_total++;
            if (halt_req && !m_grace) begin
                m_stopped = 1'b1;
            end else if (jr_taken || j_taken) begin
                m_uncondi++;
            end else if (br_taken) begin
                m_condi++;
            end else if (load_use) begin
                m_bubble++;
            end
            m_grace = 1'b0;
        end
        go_seen.push_front(go);
        void'(go_seen.pop_back());
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input bit lu, input bit br, input bit j,
                         input bit jr, input bit halt, input bit go_v);
        @(posedge clk);
        #1;
        load_use = lu;
        br_taken = br;
        j_taken  = j;
        jr_taken = jr;
        halt_req = halt;
        go       = go_v;
        exp_q.push_back(model_outputs());
        model_advance();
    endtask

    // Reset asserted between edges; its effect is checked in the same cycle
    task automatic do_reset();
        @(posedge clk);
        #1;
        load_use = 1'b0;
        br_taken = 1'b0;
        j_taken  = 1'b0;
        jr_taken = 1'b0;
        halt_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_advance();
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_en",        (pc_en       === e.pc_en)       ? 1 : 0, 1);
                chk("pc_sel",       (pc_sel      === e.pc_sel)      ? 1 : 0, 1);
                chk("if_id_en",     (if_id_en    === e.if_id_en)    ? 1 : 0, 1);
                chk("if_id_flush",  (if_id_flush === e.if_id_flush) ? 1 : 0, 1);
                chk("id_ex_en",     (id_ex_en    === e.id_ex_en)    ? 1 : 0, 1);
                chk("id_ex_flush",  (id_ex_flush === e.id_ex_flush) ? 1 : 0, 1);
                chk("running",      (running     === e.running)     ? 1 : 0, 1);
                chk("total_cycles", (^total_cycles === 1'bx) ? -1 : int'(total_cycles), e.total);
                chk("condi_num",    (^condi_num    === 1'bx) ? -1 : int'(condi_num),    e.condi);
                chk("uncondi_num",  (^uncondi_num  === 1'bx) ? -1 : int'(uncondi_num),  e.uncondi);
                chk("bubble_num",   (^bubble_num   === 1'bx) ? -1 : int'(bubble_num),   e.bubble);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst      = 1'b0;
        go       = 1'b0;
        load_use = 1'b0;
        br_taken = 1'b0;
        j_taken  = 1'b0;
        jr_taken = 1'b0;
        halt_req = 1'b0;
        model_reset();

        // Reset values, then idle running
        do_reset();
        repeat (11) drive(0, 0, 0, 0, 0, 0);

        // Load-use stall for two cycles
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Branch taken together with load-use: redirect wins
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // j and jr together: jr wins, then 16 j redirects wrap the counter
        drive(0, 0, 1, 1, 0, 0);
        repeat (16) drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Halt with a redirect and load-use pending, then ignored inputs
        drive(1, 1, 0, 0, 1, 0);
        repeat (50) drive(1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1, 0);

        // Press go with the syscall still in WB; keep halt_req up until
        // the pipeline is back in normal running
        for (int k = 0; k < 12 && (m_stopped || m_grace); k++) begin
            drive(0, 1, 0, 0, 1, 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        // go still held while a new halt happens: no resume without an edge
        drive(0, 0, 0, 0, 1, 1);
        repeat (20) drive(0, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of the halted period
        do_reset();
        repeat (4) drive(0, 0, 0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic, including halts, go presses and resets
        begin
            bit g;
            g = 1'b0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 5) == 0) g = ~g;
                if ($urandom_range(0, 199) == 0) begin
                    do_reset();
                end else begin
                    drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 24) == 0, g);
                end
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
